mem_stage: RTL and testbench

//  Load/store stage between EX and RegFile in the MIPS core. Non-memory results pass through

---
 rtl/mem_stage_pkg.sv | 54 +++++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_load_align.sv | 23 ++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the load/store stage: opcodes, FSM states, request bundle.
// Also holds the opcode decoder used by mem_stage.
package mem_stage_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic isMem;
        logic isLoad;
        logic isWord;
        logic isSigned;
    } decode_t;

    typedef struct packed {
        logic        isLoad;
        logic        isWord;
        logic        isSigned;
        logic [1:0]  lane;
        logic [29:0] wordAddr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [4:0]  rt;
    } memReq_t;

    function automatic decode_t decodeOp(input logic [5:0] op);
        decode_t d;
        d = '0;
        unique case (1'b1)
            (op == OP_LW): d = '{isMem: 1'b1, isLoad: 1'b1,
                                 isWord: 1'b1, isSigned: 1'b0};
            (op == OP_LB): d = '{isMem: 1'b1, isLoad: 1'b1,
                                 isWord: 1'b0, isSigned: 1'b1};
            (op == OP_LBU): d = '{isMem: 1'b1, isLoad: 1'b1,
                                  isWord: 1'b0, isSigned: 1'b0};
            (op == OP_SW): d = '{isMem: 1'b1, isLoad: 1'b0,
                                 isWord: 1'b1, isSigned: 1'b0};
            (op == OP_SB): d = '{isMem: 1'b1, isLoad: 1'b0,
                                 isWord: 1'b0, isSigned: 1'b0};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data RAM request/acknowledge bus between the load/store stage and memory.
// The stage is master; the RAM (or its model) is slave.
interface mem_stage_if;

    logic        memCe;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memSel;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;

    modport master (
        output memCe, memWe, memAddr, memSel, memWdata,
        input  memRdata, memAck
    );

    modport slave (
        input  memCe, memWe, memAddr, memSel, memWdata,
        output memRdata, memAck
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load formatting: picks the addressed byte lane (little-endian) and
// sign- or zero-extends it; whole words pass unchanged.
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic        isWord,
    input  logic        isSigned,
    output logic [31:0] data
);

    logic [7:0] laneByte;

    always_comb begin
        laneByte = rdata[{lane, 3'b000} +: 8];
        if (isWord)
            data = rdata;
        else if (isSigned)
            data = {{24{laneByte[7]}}, laneByte};
        else
            data = {24'h0, laneByte};
    end

endmodule

// File: rtl/mem_stage.sv
// Load/store stage: passes ALU results through, runs lw/lb/lbu/sw/sb as a
// req/ack RAM transaction and stalls fetch until it finishes.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memWdata_i,
    input  logic        regcWr_i,
    input  logic [4:0]  regcAddr_i,
    input  logic [31:0] regcData_i,
    output logic        regcWr,
    output logic [4:0]  regcAddr,
    output logic [31:0] regcData,
    output logic        stall,
    mem_stage_if.master bus,
    output logic        alignErr,
    output logic        busErr
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t          state, stateNext;
    logic [TO_W-1:0] cnt;
    memReq_t         req, reqIn;
    logic [31:0]     rdataQ;
    logic            alignQ, busQ;
    logic            stallRaw;
    logic            misalign;
    logic            timeout;
    decode_t         dec;
    logic [31:0]     loadData;

    assign dec      = decodeOp(op);
    assign misalign = dec.isWord && (memAddr_i[1:0] != 2'b00);
    assign timeout  = (cnt == CNT_LAST);

    always_comb begin
        reqIn          = '0;
        reqIn.isLoad   = dec.isLoad;
        reqIn.isWord   = dec.isWord;
        reqIn.isSigned = dec.isSigned;
        reqIn.lane     = memAddr_i[1:0];
        reqIn.wordAddr = memAddr_i[31:2];
        reqIn.rt       = regcAddr_i;
        if (dec.isWord) begin
            reqIn.sel   = 4'b1111;
            reqIn.wdata = memWdata_i;
        end else begin
            reqIn.sel   = 4'b0001 << memAddr_i[1:0];
            reqIn.wdata = {4{memWdata_i[7:0]}};
        end
    end

    load_align u_align (
        .rdata    (rdataQ),
        .lane     (req.lane),
        .isWord   (req.isWord),
        .isSigned (req.isSigned),
        .data     (loadData)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            req    <= '0;
            rdataQ <= '0;
            alignQ <= 1'b0;
            busQ   <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == IDLE && dec.isMem) begin
                req    <= reqIn;
                alignQ <= misalign;
                busQ   <= 1'b0;
                cnt    <= '0;
            end
            if (state == REQ) begin
                // A late ack still counts even on the timeout cycle.
                if (bus.memAck)
                    rdataQ <= bus.memRdata;
                else if (timeout)
                    busQ <= 1'b1;
                if (cnt != '1)
                    cnt <= cnt + TO_W'(1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        stallRaw  = 1'b0;
        regcWr    = regcWr_i;
        regcAddr  = regcAddr_i;
        regcData  = regcData_i;
        unique case (state)
            IDLE: begin
                if (dec.isMem) begin
                    stallRaw  = 1'b1;
                    regcWr    = 1'b0;
                    stateNext = misalign ? DONE : REQ;
                end
            end
            REQ: begin
                stallRaw = 1'b1;
                regcWr   = 1'b0;
                if (bus.memAck || timeout)
                    stateNext = DONE;
            end
            DONE: begin
                regcWr    = req.isLoad & ~alignQ & ~busQ;
                regcAddr  = req.rt;
                regcData  = loadData;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign stall        = stallRaw & rst;
    assign bus.memCe    = (state == REQ);
    assign bus.memWe    = (state == REQ) & ~req.isLoad;
    assign bus.memAddr  = {req.wordAddr, 2'b00};
    assign bus.memSel   = req.sel;
    assign bus.memWdata = req.wdata;
    assign alignErr     = (state == DONE) & alignQ;
    assign busErr       = (state == DONE) & busQ;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, alignment,
// ack timeout and reset in the middle of a transaction.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [31:0] memAddr_i, memWdata_i, regcData_i;
    logic        regcWr_i;
    logic [4:0]  regcAddr_i;
    logic        regcWr;
    logic [4:0]  regcAddr;
    logic [31:0] regcData;
    logic        stall, alignErr, busErr;

    int nVec = 0;
    int nBad = 0;

    mem_stage_if bus ();

    mem_stage #(.ACK_TIMEOUT(16), .TO_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .memAddr_i  (memAddr_i),
        .memWdata_i (memWdata_i),
        .regcWr_i   (regcWr_i),
        .regcAddr_i (regcAddr_i),
        .regcData_i (regcData_i),
        .regcWr     (regcWr),
        .regcAddr   (regcAddr),
        .regcData   (regcData),
        .stall      (stall),
        .bus        (bus),
        .alignErr   (alignErr),
        .busErr     (busErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic memTxn(input string tag,
                          input logic [5:0]  o,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [4:0]  rt,
                          input int          ackAt,
                          input logic [31:0] rd,
                          input logic        expReq,
                          input logic        expWe,
                          input logic [3:0]  expSel,
                          input logic [31:0] expWd,
                          input logic        expWr,
                          input logic [31:0] expData,
                          input logic        expAl,
                          input logic        expBe,
                          input int          expStall);
        int   stalls = 0;
        int   reqCycles = 0;
        logic done = 1'b0;
        logic sawReq = 1'b0;
        op         = o;
        memAddr_i  = a;
        memWdata_i = wd;
        regcAddr_i = rt;
        regcWr_i   = 1'b1;
        regcData_i = 32'hCAFE_0000;
        #1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (!stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                check({tag, ".wrStall"}, regcWr, 0);
                if (bus.memCe) begin
                    if (!sawReq) begin
                        check({tag, ".we"}, bus.memWe, expWe);
                        check({tag, ".addr"}, bus.memAddr,
                              {a[31:2], 2'b00});
                        check({tag, ".sel"}, bus.memSel, expSel);
                        check({tag, ".wdata"}, bus.memWdata, expWd);
                    end
                    sawReq = 1'b1;
                    if (reqCycles == ackAt) begin
                        bus.memAck   = 1'b1;
                        bus.memRdata = rd;
                    end
                    reqCycles++;
                end
                tick();
                bus.memAck   = 1'b0;
                bus.memRdata = 32'h1357_9BDF;
            end
        end
        check({tag, ".done"}, done, 1);
        check({tag, ".req"}, sawReq, expReq);
        check({tag, ".stalls"}, stalls, expStall);
        check({tag, ".wr"}, regcWr, expWr);
        if (expWr) begin
            check({tag, ".rt"}, regcAddr, rt);
            check({tag, ".data"}, regcData, expData);
        end
        check({tag, ".alignErr"}, alignErr, expAl);
        check({tag, ".busErr"}, busErr, expBe);
        check({tag, ".ceDone"}, bus.memCe, 0);
        tick();
        op       = 6'b000000;
        regcWr_i = 1'b0;
        #1;
        check({tag, ".errDrop"}, {alignErr, busErr}, 0);
        check({tag, ".stallDrop"}, stall, 0);
    endtask

    initial begin
        rst          = 1'b0;
        op           = 6'b000000;
        memAddr_i    = '0;
        memWdata_i   = '0;
        regcWr_i     = 1'b0;
        regcAddr_i   = '0;
        regcData_i   = '0;
        bus.memAck   = 1'b0;
        bus.memRdata = 32'h1357_9BDF;
        tick();
        check("rst.memCe", bus.memCe, 0);
        check("rst.memWe", bus.memWe, 0);
        check("rst.stall", stall, 0);
        check("rst.errs", {alignErr, busErr}, 0);
        rst = 1'b1;
        tick();

        op         = 6'b001000;
        regcData_i = 32'h0000_1234;
        regcAddr_i = 5'd5;
        regcWr_i   = 1'b1;
        #1;
        check("pass.wr", regcWr, 1);
        check("pass.addr", regcAddr, 5);
        check("pass.data", regcData, 32'h0000_1234);
        check("pass.stall", stall, 0);
        check("pass.memCe", bus.memCe, 0);
        tick();

        memTxn("lw100", 6'b100011, 32'h100, 32'h0, 5'd7, 1,
               32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h0,
               1, 32'hDEAD_BEEF, 0, 0, 3);
        memTxn("lb103", 6'b100000, 32'h103, 32'h0, 5'd8, 0,
               32'h80FF_FF00, 1, 0, 4'b1000, 32'h0,
               1, 32'hFFFF_FF80, 0, 0, 2);
        memTxn("lbu103", 6'b100100, 32'h103, 32'h0, 5'd9, 0,
               32'h80FF_FF00, 1, 0, 4'b1000, 32'h0,
               1, 32'h0000_0080, 0, 0, 2);
        memTxn("lb101", 6'b100000, 32'h101, 32'h0, 5'd10, 2,
               32'h80FF_FF00, 1, 0, 4'b0010, 32'h0,
               1, 32'hFFFF_FFFF, 0, 0, 4);
        memTxn("lbu100", 6'b100100, 32'h100, 32'h0, 5'd11, 0,
               32'h80FF_FF7F, 1, 0, 4'b0001, 32'h0,
               1, 32'h0000_007F, 0, 0, 2);
        memTxn("sb202", 6'b101000, 32'h202, 32'hABCD_EF5A, 5'd12, 0,
               32'h0, 1, 1, 4'b0100, 32'h5A5A_5A5A,
               0, 32'h0, 0, 0, 2);
        memTxn("sw300", 6'b101011, 32'h300, 32'h1122_3344, 5'd13, 1,
               32'h0, 1, 1, 4'b1111, 32'h1122_3344,
               0, 32'h0, 0, 0, 3);
        memTxn("sw301", 6'b101011, 32'h301, 32'h1122_3344, 5'd14, 0,
               32'h0, 0, 1, 4'b1111, 32'h0,
               0, 32'h0, 1, 0, 1);
        memTxn("lw402", 6'b100011, 32'h402, 32'h0, 5'd15, 0,
               32'h0, 0, 0, 4'b1111, 32'h0,
               0, 32'h0, 1, 0, 1);
        memTxn("lwTo", 6'b100011, 32'h400, 32'h0, 5'd16, -1,
               32'h0, 1, 0, 4'b1111, 32'h0,
               0, 32'h0, 0, 1, 17);

        op         = 6'b100011;
        memAddr_i  = 32'h500;
        regcAddr_i = 5'd9;
        regcWr_i   = 1'b1;
        tick();
        check("rstMid.inReq", bus.memCe, 1);
        rst = 1'b0;
        #1;
        check("rstMid.memCe", bus.memCe, 0);
        check("rstMid.stall", stall, 0);
        check("rstMid.wr", regcWr, 0);
        tick();
        op       = 6'b000000;
        regcWr_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rstMid.idle", {bus.memCe, stall}, 0);

        memTxn("lwAfter", 6'b100011, 32'h504, 32'h0, 5'd9, 0,
               32'h0F0F_0F0F, 1, 0, 4'b1111, 32'h0,
               1, 32'h0F0F_0F0F, 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nVec, nBad);
        $finish;
    end

endmodule
